// File: rtl/pe_dot_sequencer_if.sv
// Handshake and PE-side signal bundle for the dot-product sequencer.
// The slave modport is the sequencer's view; the master modport is the host and PE side.
interface pe_dot_sequencer_if #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
);
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             abort;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_act;
  logic [15:0]      in_wgt;
  logic [15:0]      pe_inputs;
  logic [15:0]      pe_weights;
  logic [31:0]      pe_result;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output start, cfg_len, abort, in_valid, in_act, in_wgt, out_ready, pe_result,
    input  busy, in_ready, pe_inputs, pe_weights, out_valid, out_data, out_ovf
  );

  modport slave (
    input  start, cfg_len, abort, in_valid, in_act, in_wgt, out_ready, pe_result,
    output busy, in_ready, pe_inputs, pe_weights, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/pe_dot_sequencer.sv
// Streams cfg_len activation/weight beats into a 4-lane PE and accumulates the
// PE results with saturation; the sum is held in DONE until taken downstream.
module pe_dot_sequencer #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_dot_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] remaining_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic             pv_reg;

  logic             fire;
  logic [ACC_W:0]   sum;
  logic             in_done;

  assign fire    = bus.in_valid && (state_reg == RUN);
  assign in_done = (state_reg == DONE);
  assign sum     = {1'b0, acc_reg} + {1'b0, bus.pe_result[ACC_W-1:0]};

  assign bus.busy      = (state_reg != IDLE);
  assign bus.in_ready  = (state_reg == RUN);
  assign bus.out_valid = in_done;
  assign bus.out_data  = in_done ? acc_reg : '0;
  assign bus.out_ovf   = in_done && ovf_reg;

  // PE operands are forced to zero outside fire cycles so idle lanes contribute nothing.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign bus.pe_inputs[4*gi+3:4*gi]  = fire ? bus.in_act[4*gi+3:4*gi] : 4'h0;
      assign bus.pe_weights[4*gi+3:4*gi] = fire ? bus.in_wgt[4*gi+3:4*gi] : 4'h0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      pv_reg        <= 1'b0;
    end else if (state_reg != IDLE && bus.abort) begin
      // Abort outranks fire, start and out_ready; an in-flight beat is dropped.
      state_reg     <= IDLE;
      remaining_reg <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      pv_reg        <= 1'b0;
    end else begin
      pv_reg <= fire;
      // PE result lags its operands by one cycle, so pv marks a result to fold in.
      if (pv_reg) begin
        if (sum[ACC_W]) begin
          acc_reg <= '1;
          ovf_reg <= 1'b1;
        end else begin
          acc_reg <= sum[ACC_W-1:0];
        end
      end
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            remaining_reg <= bus.cfg_len;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            pv_reg        <= 1'b0;
            state_reg     <= (bus.cfg_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (fire) begin
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == LEN_W'(1)) state_reg <= DRAIN;
          end
        end
        DRAIN: state_reg <= DONE;
        DONE: begin
          if (bus.out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Drives one stimulus stream into a 32-bit and a 12-bit accumulator instance,
// each with a registered 4-lane PE, and checks both against a job-level model.
module tb_pe_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_act = '0;
  logic [15:0] in_wgt = '0;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int fires  = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pe_dot_sequencer_if #(.LEN_W(8), .ACC_W(32)) bus_a ();
  pe_dot_sequencer_if #(.LEN_W(8), .ACC_W(12)) bus_b ();

  assign bus_a.start = start;     assign bus_b.start = start;
  assign bus_a.cfg_len = cfg_len; assign bus_b.cfg_len = cfg_len;
  assign bus_a.abort = abort;     assign bus_b.abort = abort;
  assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
  assign bus_a.in_act = in_act;   assign bus_b.in_act = in_act;
  assign bus_a.in_wgt = in_wgt;   assign bus_b.in_wgt = in_wgt;
  assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

  pe_dot_sequencer #(.LEN_W(8), .ACC_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  pe_dot_sequencer #(.LEN_W(8), .ACC_W(12)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  function automatic int dot4(input logic [15:0] a, input logic [15:0] w);
    int s = 0;
    for (int l = 0; l < 4; l++) s += int'(a[4*l +: 4]) * int'(w[4*l +: 4]);
    return s;
  endfunction

  // Registered PEs: one cycle from operands to result.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus_a.pe_result <= '0;
      bus_b.pe_result <= '0;
    end else begin
      bus_a.pe_result <= 32'(dot4(bus_a.pe_inputs, bus_a.pe_weights));
      bus_b.pe_result <= 32'(dot4(bus_b.pe_inputs, bus_b.pe_weights));
    end
  end

  always @(posedge clk) if (rst_n && in_valid && bus_a.in_ready && !abort) fires++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Job-level model: unbounded integer sum, saturation applied only when reported.
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;
  int     ph = P_IDLE;
  int     left = 0;
  longint msum = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = P_IDLE; msum = 0; left = 0;
    end else if (ph != P_IDLE && abort) begin
      ph = P_IDLE; msum = 0;
    end else begin
      case (ph)
        P_IDLE: if (start && !abort) begin
          msum = 0; left = int'(cfg_len);
          ph = (cfg_len == 0) ? P_DONE : P_RUN;
        end
        P_RUN: if (in_valid) begin
          msum += longint'(dot4(in_act, in_wgt));
          left--;
          if (left == 0) ph = P_DRAIN;
        end
        P_DRAIN: ph = P_DONE;
        default: if (out_ready) ph = P_IDLE;
      endcase
    end
  end

  task automatic cmp_one(input string t, input logic busy, input logic rdy, input logic ov,
                         input longint data, input logic ovf, input logic [15:0] pi,
                         input logic [15:0] pw, input longint maxv);
    bit     done = (ph == P_DONE);
    longint ed   = done ? ((msum > maxv) ? maxv : msum) : 0;
    bit     fire = (ph == P_RUN) && in_valid;
    chk({t, "_busy"},      busy, (ph != P_IDLE));
    chk({t, "_in_ready"},  rdy,  (ph == P_RUN));
    chk({t, "_out_valid"}, ov,   done);
    chk({t, "_out_data"},  data, ed);
    chk({t, "_out_ovf"},   ovf,  done && (msum > maxv));
    chk({t, "_pe_inputs"}, pi,   fire ? in_act : 16'h0);
    chk({t, "_pe_weights"}, pw,  fire ? in_wgt : 16'h0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_one("a", bus_a.busy, bus_a.in_ready, bus_a.out_valid, longint'(bus_a.out_data),
              bus_a.out_ovf, bus_a.pe_inputs, bus_a.pe_weights, 64'hFFFF_FFFF);
      cmp_one("b", bus_b.busy, bus_b.in_ready, bus_b.out_valid, longint'(bus_b.out_data),
              bus_b.out_ovf, bus_b.pe_inputs, bus_b.pe_weights, 64'hFFF);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    start = 1'b1; cfg_len = len; cyc(); start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] w);
    in_valid = 1'b1; in_act = a; in_wgt = w; cyc(); in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  int f0;
  bit ok;

  initial begin
    cyc(); cmp_en = 1'b1; cyc(); cyc();
    @(negedge clk);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_data", longint'(bus_a.out_data), 0);
    rst_n = 1'b1; cyc();

    // Single beat: 4 lanes of 1*2 = 8, visible two cycles after the fire cycle.
    do_start(8'd1);
    beat(16'h1111, 16'h2222);
    @(negedge clk); chk("t1_no_early_valid", bus_a.out_valid, 0);
    cyc();
    @(negedge clk);
    chk("t1_valid", bus_a.out_valid, 1);
    chk("t1_data", longint'(bus_a.out_data), 8);
    chk("t1_ovf", bus_a.out_ovf, 0);
    take();
    $display("txn single_beat data=%0d", 8);

    // Four all-F beats with gaps: 4 * 900 = 3600.
    f0 = fires;
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      beat(16'hFFFF, 16'hFFFF);
      if (i < 3) cyc();
    end
    in_valid = 1'b1;
    @(negedge clk); chk("t2_drain_in_ready", bus_a.in_ready, 0);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("t2_data", longint'(bus_a.out_data), 3600);
    chk("t2_fires", fires - f0, 4);
    take();
    $display("txn gapped_four data=%0d", 3600);

    // Zero-length job goes straight to DONE with a zero result.
    f0 = fires;
    in_valid = 1'b1; in_act = 16'hFFFF; in_wgt = 16'hFFFF;
    do_start(8'd0);
    @(negedge clk);
    chk("t3_valid", bus_a.out_valid, 1);
    chk("t3_data", longint'(bus_a.out_data), 0);
    take(); in_valid = 1'b0;
    chk("t3_fires", fires - f0, 0);
    $display("txn zero_len data=0");

    // Held result under backpressure; 4*8+3*7+2*6+1*5 = 70.
    do_start(8'd1);
    beat(16'h1234, 16'h5678);
    cyc();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); cfg_len = 8'd3;
      @(negedge clk);
      chk("t4_hold_valid", bus_a.out_valid, 1);
      chk("t4_hold_data", longint'(bus_a.out_data), 70);
      cyc();
    end
    start = 1'b1; take(); start = 1'b0;
    @(negedge clk); chk("t4_idle_after", bus_a.busy, 0);
    $display("txn backpressure data=%0d", 70);

    // Five all-F beats: 4500 fits 32 bits, saturates 12 bits.
    do_start(8'd5);
    for (int i = 0; i < 5; i++) beat(16'hFFFF, 16'hFFFF);
    cyc();
    @(negedge clk);
    chk("t5_b_data", longint'(bus_b.out_data), 4095);
    chk("t5_b_ovf", bus_b.out_ovf, 1);
    chk("t5_a_data", longint'(bus_a.out_data), 4500);
    take();
    $display("txn saturate a=%0d b=%0d", 4500, 4095);

    // Abort after two beats, with a coinciding fire; then abort+start in IDLE.
    do_start(8'd4);
    beat(16'hFFFF, 16'hFFFF); beat(16'hFFFF, 16'hFFFF);
    abort = 1'b1; in_valid = 1'b1; cyc(); abort = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("t6_abort_busy", bus_a.busy, 0);
    abort = 1'b1; start = 1'b1; cfg_len = 8'd2; cyc(); abort = 1'b0; start = 1'b0;
    @(negedge clk); chk("t6_idle_abort_start", bus_a.busy, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk); chk("t6_no_valid", bus_a.out_valid, 0);
    end
    $display("txn abort");

    // Reset mid-run.
    do_start(8'd3);
    beat(16'h1111, 16'h1111);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    @(negedge clk); chk("t7_rst_busy", bus_a.busy, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk); chk("t7_no_valid", bus_a.out_valid, 0);
    end
    $display("txn reset_mid_run");

    // Follow-up job: 3*5 + 15*2 = 45.
    do_start(8'd1);
    beat(16'h00F3, 16'h0025);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (bus_a.out_valid) ok = 1'b1; else cyc();
    end
    chk("t8_valid_seen", ok, 1);
    chk("t8_data", longint'(bus_a.out_data), 45);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    cyc();
    $display("txn after_abort data=%0d", 45);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
